stepper_driver: RTL

STEPPER_DRIVER -- requirements
Module: stepper_driver

---
 rtl/stepper_driver.sv | 219 +++++++++++++++++++++
 1 files changed

// File: rtl/stepper_driver.sv
// Unipolar/bipolar stepper sequencer: moves a 3-bit phase index through an
// 8-entry half-step pattern table, one step every `period_i` clocks.
//
// Optional feature: define STEPPER_RAMP_EN to start each move at twice the
// period and shorten it by RAMP_DEC after every step, down to the period.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   start_i             start a move (IDLE only)
//   pause_i             pause/resume toggle (RUN/PAUSE)
//   abort_i             abandon the move, no done pulse
//   dir_i, half_i       direction (1 = forward), step mode (1 = half-step)
//   steps_i, period_i   step count, clocks per step (clamped to >= 2)
//   coil_o              coil pattern {A,B,C,D}
//   busy_o, paused_o    RUN or PAUSE / PAUSE
//   done_o              one-cycle completion pulse
//   remain_o            steps still to go
//   position_o          signed position, wraps modulo 2^CNT_W
module stepper_driver #(
  parameter int unsigned DIV_W    = 20,
  parameter int unsigned CNT_W    = 16,
  parameter int unsigned IDLE_OFF = 1,
  parameter int unsigned RAMP_DEC = 1000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic             pause_i,
  input  logic             abort_i,
  input  logic             dir_i,
  input  logic             half_i,
  input  logic [CNT_W-1:0] steps_i,
  input  logic [DIV_W-1:0] period_i,
  output logic [3:0]       coil_o,
  output logic             busy_o,
  output logic             paused_o,
  output logic             done_o,
  output logic [CNT_W-1:0] remain_o,
  output logic [CNT_W-1:0] position_o
);

  localparam int unsigned PW = DIV_W + 1;

  typedef enum logic [1:0] {StIdle, StRun, StPause} state_e;

  state_e           state_q, state_d;
  logic [2:0]       idx_q, idx_d;
  logic [3:0]       coil_q, coil_d;
  logic [CNT_W-1:0] remain_q, remain_d;
  logic [CNT_W-1:0] pos_q, pos_d;
  logic [PW-1:0]    div_q, div_d;
  logic [DIV_W-1:0] period_q, period_d;
  logic             dir_q, dir_d;
  logic             half_q, half_d;
  logic             first_q, first_d;
  logic             done_q, done_d;

  logic [DIV_W-1:0] per_clamp;
  logic [PW-1:0]    eff_c;
  logic             step_evt;
  logic             load_move;
  logic [2:0]       delta;

  function automatic logic [3:0] phase_pat(input logic [2:0] idx);
    logic [3:0] pat;
    unique case (idx)
      3'd0: pat = 4'b1000;
      3'd1: pat = 4'b1100;
      3'd2: pat = 4'b0100;
      3'd3: pat = 4'b0110;
      3'd4: pat = 4'b0010;
      3'd5: pat = 4'b0011;
      3'd6: pat = 4'b0001;
      3'd7: pat = 4'b1001;
    endcase
    return pat;
  endfunction

  assign per_clamp = (period_i < DIV_W'(2)) ? DIV_W'(2) : period_i;

  // Full-step moves that start on an even index take a half step first so
  // they settle on the two-coil (odd) phases.
  assign delta = (half_q || (first_q && !idx_q[0])) ? 3'd1 : 3'd2;

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    coil_d    = coil_q;
    remain_d  = remain_q;
    pos_d     = pos_q;
    div_d     = div_q;
    period_d  = period_q;
    dir_d     = dir_q;
    half_d    = half_q;
    first_d   = first_q;
    done_d    = 1'b0;
    step_evt  = 1'b0;
    load_move = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          if (steps_i != '0) begin
            load_move = 1'b1;
            dir_d     = dir_i;
            half_d    = half_i;
            period_d  = per_clamp;
            remain_d  = steps_i;
            div_d     = '0;
            first_d   = 1'b1;
            coil_d    = phase_pat(idx_q);
            state_d   = StRun;
          end else begin
            done_d = 1'b1;
          end
        end
      end

      StRun: begin
        if (abort_i) begin
          state_d  = StIdle;
          remain_d = '0;
          if (IDLE_OFF != 0) coil_d = 4'b0000;
        end else if (remain_q == '0) begin
          state_d = StIdle;
          done_d  = 1'b1;
          if (IDLE_OFF != 0) coil_d = 4'b0000;
        end else if (div_q == eff_c - PW'(1)) begin
          step_evt = 1'b1;
          div_d    = '0;
          idx_d    = dir_q ? idx_q + delta : idx_q - delta;
          coil_d   = phase_pat(idx_d);
          remain_d = remain_q - CNT_W'(1);
          pos_d    = dir_q ? pos_q + CNT_W'(1) : pos_q - CNT_W'(1);
          first_d  = 1'b0;
          if (pause_i) state_d = StPause;
        end else if (pause_i) begin
          // Divider freezes on the pausing edge so resume picks up exactly here.
          state_d = StPause;
        end else begin
          div_d = div_q + PW'(1);
        end
      end

      StPause: begin
        if (abort_i) begin
          state_d  = StIdle;
          remain_d = '0;
          if (IDLE_OFF != 0) coil_d = 4'b0000;
        end else if (pause_i) begin
          state_d = StRun;
        end
      end

      default: state_d = StIdle;
    endcase
  end

`ifdef STEPPER_RAMP_EN
  logic [PW-1:0] eff_q, eff_d;
  logic [PW:0]   ramp_floor;

  assign ramp_floor = {2'b00, period_q} + (PW + 1)'(RAMP_DEC);
  assign eff_c      = eff_q;

  always_comb begin
    eff_d = eff_q;
    if (load_move) begin
      eff_d = {per_clamp, 1'b0};
    end else if (step_evt) begin
      if ({1'b0, eff_q} > ramp_floor) eff_d = eff_q - PW'(RAMP_DEC);
      else                            eff_d = {1'b0, period_q};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) eff_q <= '0;
    else        eff_q <= eff_d;
  end
`else
  assign eff_c = {1'b0, period_q};
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      idx_q    <= '0;
      coil_q   <= '0;
      remain_q <= '0;
      pos_q    <= '0;
      div_q    <= '0;
      period_q <= DIV_W'(2);
      dir_q    <= 1'b0;
      half_q   <= 1'b0;
      first_q  <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      coil_q   <= coil_d;
      remain_q <= remain_d;
      pos_q    <= pos_d;
      div_q    <= div_d;
      period_q <= period_d;
      dir_q    <= dir_d;
      half_q   <= half_d;
      first_q  <= first_d;
      done_q   <= done_d;
    end
  end

  assign coil_o     = coil_q;
  assign busy_o     = (state_q == StRun) || (state_q == StPause);
  assign paused_o   = (state_q == StPause);
  assign done_o     = done_q;
  assign remain_o   = remain_q;
  assign position_o = pos_q;

endmodule
